speicher_zugriff: RTL and testbench
===================================

Name: speicher_zugriff

Overview:
- Load/store unit directly downstream of the processor control FSM.
- Consumes LoadDatenSignal/StoreDatenSignal plus the ALU-computed address and store operand. Runs one transaction on the data memory bus, then returns DatenGeladen/DatenGespeichert so the control FSM can leave its load/store writeback states.
- Handles byte/halfword/word sizing, sign/zero extension, misalignment detection and a bus timeout.

Parameters:
- ADDR_WIDTH, 32, width of byte address and MemAdresse.
- TIMEOUT, 255, max cycles waiting for MemBereit before the access is aborted with Fehler; 0 disables the timeout.

Ports:
- Clock  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-low reset.
- LoadDatenSignal  in  1  level; control FSM is in load writeback.
- StoreDatenSignal  in  1  level; control FSM is in store writeback.
- Funct3  in  3  access type: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- Adresse  in  ADDR_WIDTH  byte address from ALU.
- SchreibDaten  in  32  store operand (rs2).
- DatenGeladen  out  1  one-cycle pulse: load complete, LadeDaten valid.
- DatenGespeichert  out  1  one-cycle pulse: store complete.
- LadeDaten  out  32  extended load result; held until the next load completes.
- Fehler  out  1  sticky misalign/timeout/illegal flag; cleared by the next accepted request.
- MemAdresse  out  ADDR_WIDTH  word-aligned address (low 2 bits 0).
- MemLesen  out  1  read strobe, held until MemBereit.
- MemSchreiben  out  1  write strobe, held until MemBereit.
- MemByteEnable  out  4  byte lanes for writes; all 1s for reads.
- MemSchreibDaten  out  32  lane-replicated store data.
- MemLeseDaten  in  32  read data, valid when MemBereit.
- MemBereit  in  1  bus ready/ack for the current strobe.

Behaviour:
- Reset (Reset=0, async):
  - State IDLE.
  - All strobes, pulses and Fehler 0; LadeDaten 0; MemAdresse/MemSchreibDaten 0; MemByteEnable 0.
  - Reset mid-transaction drops strobes immediately; no completion pulse is issued.
- States: IDLE, ZUGRIFF, FERTIG.
- IDLE:
  - LoadDatenSignal or StoreDatenSignal high at a clock edge: latch Adresse, Funct3, SchreibDaten and direction; clear Fehler.
  - Both high, or Funct3 not listed for the direction (stores accept only 000/001/010): set Fehler, go to FERTIG, no bus access.
  - Misaligned (H with addr[0]=1, W with addr[1:0]!=0): set Fehler, go to FERTIG, no bus access.
  - Otherwise go to ZUGRIFF.
- ZUGRIFF:
  - MemLesen or MemSchreiben =1; address, byte enables and data stable.
  - MemBereit=1 at an edge: capture read data (loads), go to FERTIG.
  - Wait counter increments each cycle without MemBereit. When it reaches TIMEOUT (TIMEOUT!=0): drop strobe, set Fehler, go to FERTIG; LadeDaten unchanged.
- FERTIG:
  - Exactly one cycle with DatenGeladen (load) or DatenGespeichert (store) =1, including error cases, so the control FSM never hangs. Then go to IDLE unconditionally.
- Latency: request seen at edge N; strobe during cycle N+1; with MemBereit in cycle N+1, pulse during cycle N+2. Each wait cycle adds 1. Error completion pulses in cycle N+1.
- Load extraction:
  - Lane = addr[1:0].
  - B/BU: byte lane, sign/zero extended.
  - H/HU: halfword at addr[1], extended.
  - W: full word.
- Store encoding:
  - SB: MemByteEnable = 0001 << addr[1:0], data byte replicated x4.
  - SH: 0011 << addr[1], halfword replicated x2.
  - SW: 1111.
- Request still high in IDLE right after FERTIG is not re-accepted, because the control FSM has already left its writeback state. The block does not track edges; it relies on that behaviour.
- Inputs are ignored outside IDLE.

Test Plan:
- LW addr 0x100, memory returns 0xDEADBEEF with MemBereit in the first ZUGRIFF cycle -> MemLesen for 1 cycle, DatenGeladen pulse 2 cycles after request, LadeDaten=0xDEADBEEF, Fehler=0.
- LB addr 0x103, word 0x80FF_0000 -> LadeDaten=0xFFFFFF80; same with LBU -> 0x00000080; LH addr 0x102 -> 0xFFFF80FF.
- SB addr 0x201, data 0x12345678, MemBereit delayed 3 cycles -> MemByteEnable=0010, MemSchreibDaten=0x78787878, MemAdresse=0x200, strobe held 4 cycles, one DatenGespeichert pulse.
- SW addr 0x202 -> no strobe, Fehler=1, DatenGespeichert pulse 1 cycle after request; next valid request clears Fehler.
- TIMEOUT=4, load with MemBereit never asserted -> strobe held 4 cycles then dropped, Fehler=1, DatenGeladen pulse, LadeDaten keeps the previous value.
- Reset asserted during ZUGRIFF -> MemLesen falls without a clock edge, no pulse afterwards; after release a new LW completes normally.

Source files
------------

// File: rtl/speicher_zugriff_if.sv
// Data-memory bus between the load/store unit (master) and the memory (slave).
interface speicher_zugriff_if #(
  parameter int ADDR_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] MemAdresse;
  logic                  MemLesen;
  logic                  MemSchreiben;
  logic [3:0]            MemByteEnable;
  logic [31:0]           MemSchreibDaten;
  logic [31:0]           MemLeseDaten;
  logic                  MemBereit;

  modport master (
    output MemAdresse, MemLesen, MemSchreiben, MemByteEnable, MemSchreibDaten,
    input  MemLeseDaten, MemBereit
  );

  modport slave (
    input  MemAdresse, MemLesen, MemSchreiben, MemByteEnable, MemSchreibDaten,
    output MemLeseDaten, MemBereit
  );
endinterface

// File: rtl/speicher_zugriff.sv
// Load/store unit: runs one data-memory transaction per writeback request and always
// answers with exactly one completion pulse, even on misalignment or bus timeout.
module speicher_zugriff #(
  parameter int ADDR_WIDTH = 32,
  parameter int TIMEOUT    = 255
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  LoadDatenSignal,
  input  logic                  StoreDatenSignal,
  input  logic [2:0]            Funct3,
  input  logic [ADDR_WIDTH-1:0] Adresse,
  input  logic [31:0]           SchreibDaten,
  output logic                  DatenGeladen,
  output logic                  DatenGespeichert,
  output logic [31:0]           LadeDaten,
  output logic                  Fehler,
  speicher_zugriff_if.master    memBus
);

  typedef enum logic [1:0] {IDLE, ZUGRIFF, FERTIG} stateT;

  localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT - 1);
  localparam bit          TIMEOUT_EN   = (TIMEOUT != 0);

  stateT                 state, nextState;
  logic                  isStore;
  logic [2:0]            funct3Reg;
  logic [1:0]            laneReg;
  logic [ADDR_WIDTH-1:0] addrReg;
  logic [3:0]            byteEnReg;
  logic [31:0]           storeDataReg;
  logic [31:0]           waitCount;

  logic                  requested, funct3Ok, misaligned, badRequest;
  logic                  accept, timeoutHit;
  logic [3:0]            byteEnNext;
  logic [31:0]           storeDataNext;
  logic [7:0]            laneByte;
  logic [15:0]           laneHalf;
  logic [31:0]           loadValue;

  // Both strobes high is treated as a load for the completion pulse; it is an error anyway.
  always_comb begin
    requested = LoadDatenSignal || StoreDatenSignal;
    funct3Ok  = 1'b0;
    if (StoreDatenSignal)
      funct3Ok = Funct3 inside {3'b000, 3'b001, 3'b010};
    else
      funct3Ok = Funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    misaligned = 1'b0;
    case (Funct3[1:0])
      2'b01:   misaligned = Adresse[0];
      2'b10:   misaligned = (Adresse[1:0] != 2'b00);
      default: misaligned = 1'b0;
    endcase
    badRequest = (LoadDatenSignal && StoreDatenSignal) || !funct3Ok || misaligned;
  end

  always_comb begin
    byteEnNext    = 4'b1111;
    storeDataNext = SchreibDaten;
    if (StoreDatenSignal && !LoadDatenSignal) begin
      case (Funct3[1:0])
        2'b00: begin
          byteEnNext    = 4'b0001 << Adresse[1:0];
          storeDataNext = {4{SchreibDaten[7:0]}};
        end
        2'b01: begin
          byteEnNext    = 4'b0011 << {Adresse[1], 1'b0};
          storeDataNext = {2{SchreibDaten[15:0]}};
        end
        default: begin
          byteEnNext    = 4'b1111;
          storeDataNext = SchreibDaten;
        end
      endcase
    end
  end

  always_comb begin
    laneByte = memBus.MemLeseDaten[{laneReg, 3'b000} +: 8];
    laneHalf = laneReg[1] ? memBus.MemLeseDaten[31:16] : memBus.MemLeseDaten[15:0];
    case (funct3Reg)
      3'b000:  loadValue = {{24{laneByte[7]}}, laneByte};
      3'b100:  loadValue = {24'h0, laneByte};
      3'b001:  loadValue = {{16{laneHalf[15]}}, laneHalf};
      3'b101:  loadValue = {16'h0, laneHalf};
      default: loadValue = memBus.MemLeseDaten;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset)
      state <= IDLE;
    else
      state <= nextState;
  end

  always_comb begin
    nextState  = state;
    accept     = 1'b0;
    timeoutHit = 1'b0;
    unique case (state)
      IDLE: begin
        if (requested) begin
          accept    = 1'b1;
          nextState = badRequest ? FERTIG : ZUGRIFF;
        end
      end
      ZUGRIFF: begin
        if (memBus.MemBereit) begin
          nextState = FERTIG;
        end else if (TIMEOUT_EN && (waitCount == TIMEOUT_LAST)) begin
          timeoutHit = 1'b1;
          nextState  = FERTIG;
        end
      end
      FERTIG:  nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Request context is latched once on acceptance so the bus sees stable values while waiting.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      isStore      <= 1'b0;
      funct3Reg    <= 3'b000;
      laneReg      <= 2'b00;
      addrReg      <= '0;
      byteEnReg    <= 4'b0000;
      storeDataReg <= 32'h0;
      waitCount    <= 32'h0;
      LadeDaten    <= 32'h0;
      Fehler       <= 1'b0;
    end else if (accept) begin
      isStore      <= StoreDatenSignal && !LoadDatenSignal;
      funct3Reg    <= Funct3;
      laneReg      <= Adresse[1:0];
      addrReg      <= {Adresse[ADDR_WIDTH-1:2], 2'b00};
      byteEnReg    <= byteEnNext;
      storeDataReg <= storeDataNext;
      waitCount    <= 32'h0;
      Fehler       <= badRequest;
    end else if (state == ZUGRIFF) begin
      if (memBus.MemBereit) begin
        if (!isStore)
          LadeDaten <= loadValue;
      end else if (timeoutHit) begin
        Fehler <= 1'b1;
      end else begin
        waitCount <= waitCount + 32'h1;
      end
    end
  end

  assign memBus.MemLesen        = (state == ZUGRIFF) && !isStore;
  assign memBus.MemSchreiben    = (state == ZUGRIFF) && isStore;
  assign memBus.MemAdresse      = addrReg;
  assign memBus.MemByteEnable   = byteEnReg;
  assign memBus.MemSchreibDaten = storeDataReg;
  assign DatenGeladen           = (state == FERTIG) && !isStore;
  assign DatenGespeichert       = (state == FERTIG) && isStore;

endmodule

// File: tb/tb_speicher_zugriff.sv
// Directed bench for speicher_zugriff: a transaction-level model predicts every output
// each cycle, and literal expectations pin the model on the key cases.
module tb_speicher_zugriff;

  localparam int TIMEOUT_T = 4;

  logic        Clock;
  logic        Reset;
  logic        LoadDatenSignal, StoreDatenSignal;
  logic [2:0]  Funct3;
  logic [31:0] Adresse, SchreibDaten;
  logic        DatenGeladen, DatenGespeichert, Fehler;
  logic [31:0] LadeDaten;

  int checks = 0;
  int errors = 0;

  logic        mLesen = 0, mSchreiben = 0, mGeladen = 0, mGespeichert = 0, mFehler = 0;
  logic [31:0] mLade = 0, mAddr = 0, mWdata = 0;
  logic [3:0]  mBe = 0;

  speicher_zugriff_if #(.ADDR_WIDTH(32)) memBus ();

  speicher_zugriff #(.ADDR_WIDTH(32), .TIMEOUT(TIMEOUT_T)) dut (
    .Clock            (Clock),
    .Reset            (Reset),
    .LoadDatenSignal  (LoadDatenSignal),
    .StoreDatenSignal (StoreDatenSignal),
    .Funct3           (Funct3),
    .Adresse          (Adresse),
    .SchreibDaten     (SchreibDaten),
    .DatenGeladen     (DatenGeladen),
    .DatenGespeichert (DatenGespeichert),
    .LadeDaten        (LadeDaten),
    .Fehler           (Fehler),
    .memBus           (memBus)
  );

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Outcome of one request derived from access size, lane and sign rules.
  task automatic modelRequest(input logic ld, input logic st, input logic [2:0] f3,
                              input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] rword,
                              output logic err, output logic [31:0] wAddr, output logic [3:0] be,
                              output logic [31:0] wd, output logic [31:0] loadVal);
    int size;
    int lane;
    logic [31:0] raw;
    logic [31:0] mask;
    size = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    lane = int'(addr[1:0]);
    if (ld && st)  err = 1'b1;
    else if (st)   err = !(f3 inside {3'd0, 3'd1, 3'd2});
    else           err = !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    if ((lane % size) != 0) err = 1'b1;
    wAddr = addr - 32'(lane);
    be = st ? 4'(((1 << size) - 1) << lane) : 4'hF;
    for (int i = 0; i < 4; i++) wd[8*i +: 8] = wdata[8*(i % size) +: 8];
    raw = rword >> (8 * lane);
    if (size < 4) begin
      mask = (32'd1 << (8 * size)) - 32'd1;
      raw = raw & mask;
      if (!f3[2] && raw[8*size-1]) raw = raw | ~mask;
    end
    loadVal = raw;
  endtask

  // Drives one request and walks the model through the strobe and completion cycles.
  task automatic applyStimulus(input logic ld, input logic st, input logic [2:0] f3,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [31:0] rword, input int delay);
    logic err, isSt;
    logic [31:0] wAddr, wd, loadVal;
    logic [3:0] be;
    int nStrobe;
    modelRequest(ld, st, f3, addr, wdata, rword, err, wAddr, be, wd, loadVal);
    isSt = st && !ld;
    @(negedge Clock);
    LoadDatenSignal  = ld;
    StoreDatenSignal = st;
    Funct3           = f3;
    Adresse          = addr;
    SchreibDaten     = wdata;
    memBus.MemLeseDaten = rword;
    @(posedge Clock); #1;
    LoadDatenSignal  = 1'b0;
    StoreDatenSignal = 1'b0;
    mFehler = err;
    if (!err) begin
      nStrobe = (delay < TIMEOUT_T) ? delay + 1 : TIMEOUT_T;
      mAddr = wAddr;
      mBe = be;
      mWdata = wd;
      for (int k = 0; k < nStrobe; k++) begin
        mLesen = !isSt;
        mSchreiben = isSt;
        memBus.MemBereit = (k == delay);
        @(posedge Clock); #1;
      end
      memBus.MemBereit = 1'b0;
      mLesen = 1'b0;
      mSchreiben = 1'b0;
      if (delay >= TIMEOUT_T) mFehler = 1'b1;
      else if (!isSt) mLade = loadVal;
    end
    mGeladen = !isSt;
    mGespeichert = isSt;
    @(posedge Clock); #1;
    mGeladen = 1'b0;
    mGespeichert = 1'b0;
  endtask

  always @(negedge Clock) begin
    checkOutput("MemLesen", 32'(memBus.MemLesen), 32'(mLesen));
    checkOutput("MemSchreiben", 32'(memBus.MemSchreiben), 32'(mSchreiben));
    checkOutput("DatenGeladen", 32'(DatenGeladen), 32'(mGeladen));
    checkOutput("DatenGespeichert", 32'(DatenGespeichert), 32'(mGespeichert));
    checkOutput("Fehler", 32'(Fehler), 32'(mFehler));
    checkOutput("LadeDaten", LadeDaten, mLade);
    if (mLesen || mSchreiben) begin
      checkOutput("MemAdresse", memBus.MemAdresse, mAddr);
      checkOutput("MemByteEnable", 32'(memBus.MemByteEnable), 32'(mBe));
    end
    if (mSchreiben)
      checkOutput("MemSchreibDaten", memBus.MemSchreibDaten, mWdata);
  end

  initial begin
    #100000;
    errors++;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int strobeCount;
    Reset = 1'b0;
    LoadDatenSignal = 1'b0;
    StoreDatenSignal = 1'b0;
    Funct3 = 3'b000;
    Adresse = 32'h0;
    SchreibDaten = 32'h0;
    memBus.MemBereit = 1'b0;
    memBus.MemLeseDaten = 32'h0;
    @(negedge Clock); @(negedge Clock);
    checkOutput("reset LadeDaten", LadeDaten, 32'h0);
    checkOutput("reset MemAdresse", memBus.MemAdresse, 32'h0);
    checkOutput("reset MemByteEnable", 32'(memBus.MemByteEnable), 32'h0);
    checkOutput("reset MemSchreibDaten", memBus.MemSchreibDaten, 32'h0);
    Reset = 1'b1;

    applyStimulus(1, 0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 0);
    checkOutput("lw result", LadeDaten, 32'hDEADBEEF);
    applyStimulus(1, 0, 3'b000, 32'h103, 32'h0, 32'h80FF_0000, 0);
    checkOutput("lb result", LadeDaten, 32'hFFFFFF80);
    applyStimulus(1, 0, 3'b100, 32'h103, 32'h0, 32'h80FF_0000, 1);
    checkOutput("lbu result", LadeDaten, 32'h00000080);
    applyStimulus(1, 0, 3'b001, 32'h102, 32'h0, 32'h80FF_0000, 0);
    checkOutput("lh result", LadeDaten, 32'hFFFF80FF);
    applyStimulus(1, 0, 3'b101, 32'h102, 32'h0, 32'h80FF_0000, 2);
    checkOutput("lhu result", LadeDaten, 32'h000080FF);

    fork
      applyStimulus(0, 1, 3'b000, 32'h201, 32'h12345678, 32'h0, 3);
      begin
        @(negedge Clock); @(negedge Clock);
        checkOutput("sb byteEnable", 32'(memBus.MemByteEnable), 32'h2);
        checkOutput("sb data", memBus.MemSchreibDaten, 32'h78787878);
        checkOutput("sb address", memBus.MemAdresse, 32'h200);
        strobeCount = 0;
        for (int i = 0; i < 6; i++) begin
          if (memBus.MemSchreiben) strobeCount++;
          if (i < 5) @(negedge Clock);
        end
        checkOutput("sb strobe cycles", 32'(strobeCount), 32'd4);
      end
    join

    applyStimulus(0, 1, 3'b001, 32'h202, 32'hCAFEF00D, 32'h0, 1);
    applyStimulus(0, 1, 3'b010, 32'h202, 32'h11112222, 32'h0, 0);
    checkOutput("sw misaligned Fehler", 32'(Fehler), 32'd1);
    applyStimulus(0, 1, 3'b010, 32'h300, 32'hA5A5A5A5, 32'h0, 0);
    checkOutput("sw clears Fehler", 32'(Fehler), 32'd0);
    applyStimulus(1, 0, 3'b010, 32'h104, 32'h0, 32'h55555555, 100);
    checkOutput("timeout Fehler", 32'(Fehler), 32'd1);
    checkOutput("timeout keeps LadeDaten", LadeDaten, 32'h000080FF);
    applyStimulus(0, 1, 3'b100, 32'h300, 32'h1, 32'h0, 0);
    checkOutput("illegal store Fehler", 32'(Fehler), 32'd1);
    applyStimulus(1, 0, 3'b001, 32'h101, 32'h0, 32'h12345678, 0);
    applyStimulus(1, 0, 3'b010, 32'h108, 32'h0, 32'h0F0F0F0F, 1);
    checkOutput("lw after error", LadeDaten, 32'h0F0F0F0F);
    checkOutput("lw after error Fehler", 32'(Fehler), 32'd0);

    // Reset in the middle of a bus wait must drop the strobe at once.
    @(negedge Clock);
    LoadDatenSignal = 1'b1;
    Funct3 = 3'b010;
    Adresse = 32'h400;
    memBus.MemLeseDaten = 32'h0BAD0BAD;
    @(posedge Clock); #1;
    LoadDatenSignal = 1'b0;
    mLesen = 1'b1;
    mAddr = 32'h400;
    mBe = 4'hF;
    mFehler = 1'b0;
    @(posedge Clock); #1;
    #1 Reset = 1'b0;
    #1;
    mLesen = 1'b0;
    mLade = 32'h0;
    mFehler = 1'b0;
    checkOutput("reset drops MemLesen", 32'(memBus.MemLesen), 32'd0);
    checkOutput("reset clears LadeDaten", LadeDaten, 32'h0);
    repeat (2) @(negedge Clock);
    Reset = 1'b1;
    repeat (3) @(negedge Clock);
    applyStimulus(1, 0, 3'b010, 32'h104, 32'h0, 32'h13579BDF, 1);
    checkOutput("lw after reset", LadeDaten, 32'h13579BDF);

    repeat (2) @(negedge Clock);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
